fp_div_seq: RTL and testbench
=============================

Name: fp_div_seq

Overview:
Iterative IEEE-754 single-precision divider (OUT = A / B) for the extended-ALU path. It is the inverse companion of the combinational FP multiplier.
- Uses a start/busy/done handshake; the EX stage stalls on busy.
- Produces one quotient bit per cycle by radix-2 restoring division of the mantissas.
- Result format matches the rest of the FP datapath: flush-to-zero, round toward zero.

Parameters:
MANT_W, 24, mantissa width including the hidden bit (fixed for binary32; kept only for readability)
NAN_CANON, 32'h7FC00000, canonical quiet NaN returned for every invalid operation

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
start  in  1  request; sampled only in IDLE
A  in  32  dividend (binary32), sampled with start
B  in  32  divisor (binary32), sampled with start
busy  out  1  high while an operation is in flight
done  out  1  one-cycle pulse when OUT and the flags are valid
OUT  out  32  quotient; holds until the next accepted start
dz  out  1  divide-by-zero flag, valid with done
ov  out  1  overflow flag, valid with done
uf  out  1  underflow flag, valid with done

Behaviour:
- Reset (rst=1 at a clock edge):
  - State returns to IDLE.
  - busy=0, done=0, OUT=0, dz=ov=uf=0.
  - An operation in flight is abandoned with no done pulse.
- States and transitions:
  - IDLE: start=1 latches A and B, clears the flags, and goes to CHECK.
  - CHECK (1 cycle): a special-case operand goes to FIN; otherwise load the divider and go to DIV.
  - DIV: runs exactly 25 cycles, then goes to NORM.
  - NORM (1 cycle): goes to FIN.
  - FIN: pulses done for 1 cycle, then returns to IDLE.
- busy is 1 in CHECK, DIV and NORM; it is 0 in IDLE and FIN.
- start while busy=1 or in FIN is ignored and not queued.
- Latency, measured from the edge that sampled start:
  - Special case: done is high 2 cycles later.
  - Normal operands: done is high 28 cycles later.
  - Back-to-back: a new start is accepted in the cycle after done.
- Input decode:
  - Exponent 0 (zero or denormal) is treated as ±0.
  - Exponent 255 with mantissa 0 is ±inf.
  - Exponent 255 with mantissa ≠0 is NaN.
  - Result sign = A[31] ^ B[31], except NaN, which has sign 0.
- Special cases (priority order):
  1. Either operand NaN → NAN_CANON.
  2. inf/inf or 0/0 → NAN_CANON.
  3. inf/x → signed inf.
  4. x/0 with x finite nonzero → signed inf, dz=1.
  5. x/inf or 0/x → signed zero.
- Normal path:
  - Mantissas: mA = {1, A[22:0]}, mB = {1, B[22:0]}.
  - Each DIV cycle: if rem ≥ mB, set the q bit to 1 and rem −= mB; then rem <<= 1.
  - rem starts at mA and is 25 bits wide; q is 25 bits, shifted in MSB-first.
  - Exponent is computed in 10-bit signed arithmetic: e = eA − eB + 127.
- NORM:
  - If q[24]=1, the mantissa is q[23:1] with e unchanged.
  - Otherwise the mantissa is q[22:0] and e −= 1.
  - Remaining bits are truncated (round toward zero).
- Range checks:
  - e ≥ 255 → signed inf, ov=1.
  - e ≤ 0 → signed zero, uf=1 (no denormal output).
- Flags are cleared on the next accepted start.

Test Plan:
- Normal divide: A=0x40C00000 (6.0), B=0x40000000 (2.0), start 1 cycle → done 28 cycles after start, OUT=0x40400000, no flags.
- Truncation: A=0x3F800000, B=0x40400000 → OUT=0x3EAAAAAA (not …AB).
- Mixed sign with mA<mB: A=0xBF800000, B=0x3FC00000 → OUT=0xBF2AAAAA.
- Special cases, each with done 2 cycles after start:
  - 1.0/0 → 0x7F800000, dz=1.
  - 0/0 → 0x7FC00000.
  - NaN/1 → 0x7FC00000.
  - 0x80000000/2.0 → 0x80000000.
  - Denormal 0x00000001/1.0 → 0x00000000.
- Range limits:
  - A=0x7F000000, B=0x3E800000 → OUT=0x7F800000, ov=1.
  - A=0x00800000, B=0x40000000 → OUT=0, uf=1.
- Handshake robustness:
  - start re-asserted with new operands at cycle 10 of a busy operation → ignored, first result unchanged.
  - rst=1 at cycle 12 → next cycle busy=0, OUT=0, no done pulse.
  - New start immediately afterwards completes normally.

Source files
------------

// File: rtl/fp_div_seq_if.sv
// Handshake and operand/result bundle for the sequential binary32 divider.
// The master issues start with operands; the slave returns busy/done, the quotient and the flags.
interface fp_div_seq_if;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [31:0] OUT;
  logic        dz;
  logic        ov;
  logic        uf;

  modport master (
    output start, A, B,
    input  busy, done, OUT, dz, ov, uf
  );

  modport slave (
    input  start, A, B,
    output busy, done, OUT, dz, ov, uf
  );
endinterface

// File: rtl/fp_div_seq.sv
// Iterative binary32 divider: radix-2 restoring mantissa division, one quotient bit per cycle,
// flush-to-zero inputs/outputs and round toward zero.
module fp_div_seq #(
  parameter int          MANT_W    = 24,
  parameter logic [31:0] NAN_CANON = 32'h7FC00000
) (
  input logic         clk,
  input logic         rst,
  fp_div_seq_if.slave bus
);

  localparam int DIV_CYCLES = MANT_W + 1;

  typedef enum logic [2:0] {IDLE, CHECK, DIV, NORM, FIN} state_t;

  state_t state, nxt;
  logic [4:0] cnt;

  logic [31:0]              a_q, b_q;
  logic [MANT_W:0]          rem, quo;
  logic signed [9:0]        exp_q;
  logic                     sign_q;

  logic [31:0] out_r;
  logic        dz_r, ov_r, uf_r;

  // Operand classification of the latched operands
  logic [7:0] ea, eb;
  logic       a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, special;
  logic       sign_ab;

  assign ea      = a_q[30:23];
  assign eb      = b_q[30:23];
  assign a_zero  = (ea == 8'h00);
  assign b_zero  = (eb == 8'h00);
  assign a_inf   = (ea == 8'hFF) && (a_q[22:0] == 23'd0);
  assign b_inf   = (eb == 8'hFF) && (b_q[22:0] == 23'd0);
  assign a_nan   = (ea == 8'hFF) && (a_q[22:0] != 23'd0);
  assign b_nan   = (eb == 8'hFF) && (b_q[22:0] != 23'd0);
  assign special = a_zero | b_zero | a_inf | b_inf | a_nan | b_nan;
  assign sign_ab = a_q[31] ^ b_q[31];

  // Returns {dz, result} for a non-normal operand pair, in priority order.
  function automatic logic [32:0] special_result(
    input logic s, input logic an, input logic bn, input logic ai,
    input logic bi, input logic az, input logic bz
  );
    if (an || bn)                    return {1'b0, NAN_CANON};
    else if ((ai && bi) || (az && bz)) return {1'b0, NAN_CANON};
    else if (ai)                     return {1'b0, s, 8'hFF, 23'd0};
    else if (bz)                     return {1'b1, s, 8'hFF, 23'd0};
    else                             return {1'b0, s, 31'd0};
  endfunction

  // Saturates the biased exponent: returns {ov, uf, result}.
  function automatic logic [33:0] range_pack(
    input logic s, input logic signed [9:0] e, input logic [22:0] m
  );
    if (e >= 10'sd255)     return {2'b10, s, 8'hFF, 23'd0};
    else if (e <= 10'sd0)  return {2'b01, s, 31'd0};
    else                   return {2'b00, s, e[7:0], m};
  endfunction

  logic [32:0]       spec_res;
  logic signed [9:0] exp_calc, exp_adj;
  logic [22:0]       mant_norm;
  logic [33:0]       norm_res;
  logic [MANT_W:0]   mb_ext, diff;
  logic              q_bit;

  assign spec_res  = special_result(sign_ab, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero);
  assign exp_calc  = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;
  assign mb_ext    = {2'b01, b_q[22:0]};
  assign q_bit     = (rem >= mb_ext);
  assign diff      = q_bit ? (rem - mb_ext) : rem;
  // A leading zero quotient bit means mA < mB: take one more bit and drop the exponent.
  assign exp_adj   = quo[MANT_W] ? exp_q : (exp_q - 10'sd1);
  assign mant_norm = quo[MANT_W] ? quo[MANT_W-1:1] : quo[MANT_W-2:0];
  assign norm_res  = range_pack(sign_q, exp_adj, mant_norm);

  // State register and DIV cycle counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 5'd0;
    end else begin
      state <= nxt;
      if (state == DIV) cnt <= cnt + 5'd1;
      else              cnt <= 5'd0;
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (bus.start) nxt = CHECK;
      CHECK:   nxt = special ? FIN : DIV;
      DIV:     if (cnt == 5'(DIV_CYCLES - 1)) nxt = NORM;
      NORM:    nxt = FIN;
      FIN:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (state)
      CHECK, DIV, NORM: bus.busy = 1'b1;
      FIN:              bus.done = 1'b1;
      default:          ;
    endcase
  end

  // Datapath registers: operands, remainder, quotient, exponent
  always_ff @(posedge clk) begin
    case (state)
      IDLE: begin
        if (bus.start) begin
          a_q <= bus.A;
          b_q <= bus.B;
        end
      end
      CHECK: begin
        rem    <= {2'b01, a_q[22:0]};
        quo    <= '0;
        exp_q  <= exp_calc;
        sign_q <= sign_ab;
      end
      DIV: begin
        rem <= {diff[MANT_W-1:0], 1'b0};
        quo <= {quo[MANT_W-1:0], q_bit};
      end
      default: ;
    endcase
  end

  // Result and flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      out_r <= 32'd0;
      dz_r  <= 1'b0;
      ov_r  <= 1'b0;
      uf_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            dz_r <= 1'b0;
            ov_r <= 1'b0;
            uf_r <= 1'b0;
          end
        end
        CHECK: begin
          if (special) begin
            out_r <= spec_res[31:0];
            dz_r  <= spec_res[32];
          end
        end
        NORM: begin
          out_r <= norm_res[31:0];
          ov_r  <= norm_res[33];
          uf_r  <= norm_res[32];
        end
        default: ;
      endcase
    end
  end

  assign bus.OUT = out_r;
  assign bus.dz  = dz_r;
  assign bus.ov  = ov_r;
  assign bus.uf  = uf_r;

endmodule

// File: tb/tb_fp_div_seq.sv
// Directed-vector bench for fp_div_seq: latency, quotient, flags, special cases and handshake.
module tb_fp_div_seq;

  logic clk = 1'b0;
  logic rst;
  int   n_err = 0;
  int   n_chk = 0;

  always #5 clk = ~clk;

  fp_div_seq_if bus ();

  fp_div_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Latency counts rising edges from the one that samples start to the one that sees done high.
  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input int exp_lat, input logic [31:0] exp_out,
                       input logic [2:0] exp_flags, input int inject_at);
    int   lat;
    logic seen;
    logic busy0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    @(posedge clk);
    lat   = 0;
    seen  = 1'b0;
    busy0 = 1'b0;
    while (!seen && lat < 60) begin
      @(negedge clk);
      if (lat == 0) busy0 = bus.busy;
      if (lat == inject_at) begin
        bus.start = 1'b1;
        bus.A     = 32'h3F800000;
        bus.B     = 32'h40400000;
      end else begin
        bus.start = 1'b0;
      end
      seen = bus.done;
      @(posedge clk);
      lat++;
    end
    #1;
    chk({tag, " busy"}, 32'(busy0), 32'd1);
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " out"}, bus.OUT, exp_out);
    chk({tag, " flags dz/ov/uf"}, 32'({bus.dz, bus.ov, bus.uf}), 32'(exp_flags));
    chk({tag, " done pulse width"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.A     = 32'd0;
    bus.B     = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset done", 32'(bus.done), 32'd0);
    chk("reset out", bus.OUT, 32'd0);
    chk("reset flags", 32'({bus.dz, bus.ov, bus.uf}), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    do_op("6/2",        32'h40C00000, 32'h40000000, 28, 32'h40400000, 3'b000, -1);
    do_op("1/3 trunc",  32'h3F800000, 32'h40400000, 28, 32'h3EAAAAAA, 3'b000, -1);
    do_op("-1/1.5",     32'hBF800000, 32'h3FC00000, 28, 32'hBF2AAAAA, 3'b000, -1);
    do_op("1/0",        32'h3F800000, 32'h00000000, 2,  32'h7F800000, 3'b100, -1);
    do_op("-2/0",       32'hC0000000, 32'h00000000, 2,  32'hFF800000, 3'b100, -1);
    do_op("0/0",        32'h00000000, 32'h00000000, 2,  32'h7FC00000, 3'b000, -1);
    do_op("nan/1",      32'h7FC00000, 32'h3F800000, 2,  32'h7FC00000, 3'b000, -1);
    do_op("nan/0",      32'hFF800001, 32'h00000000, 2,  32'h7FC00000, 3'b000, -1);
    do_op("inf/inf",    32'h7F800000, 32'hFF800000, 2,  32'h7FC00000, 3'b000, -1);
    do_op("inf/-2",     32'h7F800000, 32'hC0000000, 2,  32'hFF800000, 3'b000, -1);
    do_op("2/inf",      32'h40000000, 32'h7F800000, 2,  32'h00000000, 3'b000, -1);
    do_op("-0/2",       32'h80000000, 32'h40000000, 2,  32'h80000000, 3'b000, -1);
    do_op("denorm/1",   32'h00000001, 32'h3F800000, 2,  32'h00000000, 3'b000, -1);
    do_op("overflow",   32'h7F000000, 32'h3E800000, 28, 32'h7F800000, 3'b010, -1);
    do_op("underflow",  32'h00800000, 32'h40000000, 28, 32'h00000000, 3'b001, -1);
    do_op("ignored start", 32'h40C00000, 32'h40000000, 28, 32'h40400000, 3'b000, 10);

    // Abort an operation mid-flight with reset.
    @(negedge clk);
    bus.start = 1'b1;
    bus.A     = 32'h40C00000;
    bus.B     = 32'h40000000;
    @(posedge clk);
    repeat (12) begin
      @(negedge clk);
      bus.start = 1'b0;
      @(posedge clk);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort busy", 32'(bus.busy), 32'd0);
    chk("abort done", 32'(bus.done), 32'd0);
    chk("abort out", bus.OUT, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    do_op("after reset", 32'hBF800000, 32'h3FC00000, 28, 32'hBF2AAAAA, 3'b000, -1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
